// File: rtl/interval_timer_if.sv
// Bus bundle for interval_timer.
//   master drives: en, load, period_in, mode_in, start
//   slave  drives: tick, wave, busy, count
interface interval_timer_if #(
  parameter int unsigned WIDTH = 28
) ();
  localparam int unsigned MODE_W = 2;

  logic              en;
  logic              load;
  logic [WIDTH-1:0]  period_in;
  logic [MODE_W-1:0] mode_in;
  logic              start;
  logic              tick;
  logic              wave;
  logic              busy;
  logic [WIDTH-1:0]  count;

  modport master (
    output en, load, period_in, mode_in, start,
    input  tick, wave, busy, count
  );

  modport slave (
    input  en, load, period_in, mode_in, start,
    output tick, wave, busy, count
  );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: divides clk by a runtime-loaded period P
// (0 treated as 1) in one of three modes:
//   SQUARE  (0)   : wave toggles on every terminal count (period 2*P, 50 %)
//   PULSE   (1,3) : one-cycle tick every P cycles, wave held low
//   ONESHOT (2)   : start opens a P-cycle gate on wave, retriggerable
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of interval_timer_if
//        in : en, load, period_in, mode_in, start
//        out: tick, wave, count (registered); busy (comb from en/mode/state)
module interval_timer #(
  parameter int unsigned WIDTH          = 28,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  interval_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_SQUARE  = 2'd0,
    MODE_PULSE   = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_PULSE_3 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  mode_e            mode_q, mode_d;
  state_e           state_q, state_d;
  logic             wave_q, wave_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] peff;
  logic             terminal;
  logic             oneshot;
  logic             running;

  // Effective period: a programmed 0 behaves as 1 so the counter never wraps.
  assign peff     = (period_q == '0) ? WIDTH'(1) : period_q;
  assign terminal = (count_q == (peff - WIDTH'(1)));
  assign oneshot  = (mode_q == MODE_ONESHOT);
  assign running  = oneshot ? (state_q == S_RUN) : 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      mode_q   <= MODE_SQUARE;
      state_q  <= S_IDLE;
      wave_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      state_q  <= state_d;
      wave_q   <= wave_d;
      tick_q   <= tick_d;
    end
  end

  // Next state: load beats start beats counting; tick only on a terminal edge.
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    state_d  = state_q;
    wave_d   = wave_q;
    tick_d   = 1'b0;

    if (bus.load) begin
      period_d = bus.period_in;
      mode_d   = mode_e'(bus.mode_in);
      count_d  = '0;
      wave_d   = 1'b0;
      state_d  = S_IDLE;
    end else if (oneshot && bus.start && bus.en) begin
      // Fresh trigger or retrigger: restart the gate window from zero.
      state_d = S_RUN;
      count_d = '0;
      wave_d  = 1'b1;
    end else if (bus.en && running) begin
      if (terminal) begin
        count_d = '0;
        tick_d  = 1'b1;
        case (mode_q)
          MODE_SQUARE:  wave_d = ~wave_q;
          MODE_ONESHOT: begin
            state_d = S_DONE;
            wave_d  = 1'b0;
          end
          default:      wave_d = 1'b0;
        endcase
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  assign bus.tick  = tick_q;
  assign bus.wave  = wave_q;
  assign bus.count = count_q;
  // busy is the only combinational output: it mirrors en outside one-shot mode.
  assign bus.busy  = oneshot ? (state_q == S_RUN) : bus.en;

endmodule
